jtag_uart_rx_stream: RTL

Host-to-FPGA receive path for boards whose only console is the internal JTAG UART. Accepts bytes strobed out of the JTAG-UART host-to-fabric port (t_dat/t_ena/t_dav), buffers them in a small FIFO, and presents them as an 8-bit AXI-stream master with tlast marking end-of-line. It sits beside the transmit pipeline in the board top level and feeds a command consumer (e.g. corescorecore control input); it pairs with the existing fabric-to-host path on the same alt_jtag_atlantic instance.

---
 rtl/jtag_uart_pkg.sv | 15 +
 rtl/jtag_uart_rx_stream_if.sv | 15 +
 rtl/jtag_rx_fifo.sv | 47 ++++
 rtl/jtag_uart_rx_stream.sv | 57 +++++
 4 files changed

// File: rtl/jtag_uart_pkg.sv
// jtag_uart_pkg: shared constants and types for the JTAG-UART receive stream.
//   BYTE_W      - width of a UART byte
//   OVF_W       - width of the saturating dropped-byte counter
//   EOL_DEFAULT - byte value that closes a line (tagged with tlast)
//   stream_state_t - occupancy state of the receive buffer
package jtag_uart_pkg;
    localparam int BYTE_W = 8;
    localparam int OVF_W = 8;
    localparam logic [BYTE_W-1:0] EOL_DEFAULT = 8'h0A;
    typedef enum logic [1:0] {
        IDLE,
        STREAMING,
        FULL
    } stream_state_t;
endpackage

// File: rtl/jtag_uart_rx_stream_if.sv
// jtag_uart_rx_stream_if: 8-bit AXI-stream byte channel with end-of-line marker.
//   tdata  - stream byte
//   tlast  - high with the end-of-line byte
//   tvalid - byte valid
//   tready - consumer ready
//   master - producer side, slave - consumer side
interface jtag_uart_rx_stream_if;
    import jtag_uart_pkg::*;
    logic [BYTE_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;
    modport master (output tdata, tlast, tvalid, input tready);
    modport slave (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/jtag_rx_fifo.sv
// jtag_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n - clock, synchronous active-low reset
//   push, din  - write request and data (ignored when full without a pop)
//   pop        - read request, advances the head
//   dout       - head entry, valid whenever count != 0
//   count      - occupancy 0..2^L
//   full       - count == 2^L
module jtag_rx_fifo
    import jtag_uart_pkg::*;
#(
    parameter int W = BYTE_W + 1,
    parameter int L = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [L:0]   count,
    output logic         full
);
    localparam int DEPTH = 1 << L;
    localparam int CW = L + 1;
    logic [W-1:0] mem [DEPTH];
    logic [L-1:0] wp, rp;
    logic         wr, rd;
    assign full = count == CW'(DEPTH);
    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
    assign wr = push & (~full | pop);
    assign rd = pop & (count != '0);
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + L'(wr);
            rp <= rp + L'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/jtag_uart_rx_stream.sv
// jtag_uart_rx_stream: JTAG-UART host-to-fabric bytes buffered into an AXI stream with tlast on EOL.
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_t_dat, i_t_ena - byte and one-cycle strobe from the JTAG UART
//   o_t_dav          - registered space-available flag back to the UART
//   axis             - stream master (tdata, tlast, tvalid / tready)
//   o_ovf_cnt        - saturating count of bytes dropped because the buffer was full
module jtag_uart_rx_stream
    import jtag_uart_pkg::*;
#(
    parameter int LOG2_DEPTH = 3,
    parameter int DAV_MARGIN = 2,
    parameter logic [BYTE_W-1:0] EOL = EOL_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [BYTE_W-1:0]           i_t_dat,
    input  logic                        i_t_ena,
    output logic                        o_t_dav,
    jtag_uart_rx_stream_if.master       axis,
    output logic [OVF_W-1:0]            o_ovf_cnt
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW = LOG2_DEPTH + 1;
    stream_state_t     state;
    logic              pop, acc, drop, full;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BYTE_W:0]   head;
    assign pop = axis.tvalid & axis.tready;
    assign acc = i_t_ena & (~full | pop);
    assign drop = i_t_ena & ~acc;
    assign cnt_n = cnt + CW'(acc) - CW'(pop);
    assign axis.tvalid = state != IDLE;
    assign axis.tdata = head[BYTE_W-1:0];
    assign axis.tlast = head[BYTE_W];
    jtag_rx_fifo #(.W(BYTE_W + 1), .L(LOG2_DEPTH)) fifo (
        .clk(i_clk),
        .rst_n(i_rst_n),
        .push(acc),
        .pop(pop),
        .din({i_t_dat == EOL, i_t_dat}),
        .dout(head),
        .count(cnt),
        .full(full)
    );
    // State tracks the next occupancy so tvalid is a registered output aligned with the FIFO count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            o_t_dav <= 1'b0;
            o_ovf_cnt <= '0;
        end else begin
            state <= cnt_n == '0 ? IDLE : cnt_n == CW'(DEPTH) ? FULL : STREAMING;
            o_t_dav <= cnt_n < CW'(DEPTH - DAV_MARGIN);
            if (drop && o_ovf_cnt != '1) o_ovf_cnt <= o_ovf_cnt + 1'b1;
        end
    end
endmodule
